// File: rtl/crc_stream_pkg.sv
// crc_stream_pkg: shared types and constants for the streaming CRC engine.
//   state_e        - frame FSM states
//   CRC16_*        - polynomial / init / xor-out / residue presets
//   be_popcount()  - number of enabled bytes in a byte-enable vector
package crc_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_e;

    // CRC-16/XMODEM
    localparam logic [15:0] CRC16_XMODEM_POLY      = 16'h1021;
    localparam logic [15:0] CRC16_XMODEM_INIT      = 16'h0000;
    localparam logic [15:0] CRC16_XMODEM_XOR_OUT   = 16'h0000;
    localparam logic [15:0] CRC16_XMODEM_CHECK_RES = 16'h0000;

    // CRC-16/CCITT-FALSE
    localparam logic [15:0] CRC16_CCITT_FALSE_POLY      = 16'h1021;
    localparam logic [15:0] CRC16_CCITT_FALSE_INIT      = 16'hFFFF;
    localparam logic [15:0] CRC16_CCITT_FALSE_XOR_OUT   = 16'h0000;
    localparam logic [15:0] CRC16_CCITT_FALSE_CHECK_RES = 16'h0000;

    // Count of set bits in a byte-enable vector (up to 8 lanes).
    function automatic logic [3:0] be_popcount(input logic [7:0] be);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + 4'(be[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/crc_step.sv
// crc_step: combinational multi-byte CRC update, MSB byte first.
//   i_crc    - current CRC register
//   i_data   - beat data, MSB byte processed first
//   i_nbytes - number of leading (MSB-side) bytes to fold in
//   o_crc    - CRC after folding i_nbytes bytes
module crc_step #(
    parameter int unsigned         CRC_W  = 16,
    parameter int unsigned         DATA_W = 16,
    parameter logic [CRC_W-1:0]    POLY   = CRC_W'(16'h1021),
    localparam int unsigned        NB     = DATA_W / 8,
    localparam int unsigned        NBW    = $clog2(NB + 1)
) (
    input  logic [CRC_W-1:0]  i_crc,
    input  logic [DATA_W-1:0] i_data,
    input  logic [NBW-1:0]    i_nbytes,
    output logic [CRC_W-1:0]  o_crc
);

    logic [CRC_W-1:0] w_acc;
    logic [CRC_W-1:0] w_tmp;
    logic [7:0]       w_byte;
    logic             w_fb;

    // Per byte: bit-serial update, then keep it only if the byte is enabled.
    always_comb begin
        w_acc  = i_crc;
        w_tmp  = '0;
        w_byte = '0;
        w_fb   = 1'b0;
        for (int b = 0; b < int'(NB); b++) begin
            w_byte = i_data[DATA_W-1-8*b -: 8];
            w_tmp  = w_acc;
            for (int k = 7; k >= 0; k--) begin
                w_fb  = w_tmp[CRC_W-1] ^ w_byte[k];
                w_tmp = {w_tmp[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
            end
            if (NBW'(b) < i_nbytes) begin
                w_acc = w_tmp;
            end
        end
        o_crc = w_acc;
    end

endmodule

// File: rtl/crc_stream_engine.sv
// crc_stream_engine: framed streaming CRC generator / checker.
//   clk, rst                 - clock, synchronous active-high reset
//   in_valid/in_ready        - input beat handshake
//   in_data, in_sof, in_eof  - beat payload and framing (MSB byte first)
//   in_be                    - MSB-aligned byte enables, honoured on eof beats
//   out_valid/out_ready      - result handshake, result held until taken
//   out_crc                  - final CRC after XOR_OUT
//   out_ok                   - raw register matched CHECK_RES
//   out_abort                - one-cycle pulse when sof restarted an open frame
module crc_stream_engine
    import crc_stream_pkg::*;
#(
    parameter int unsigned      DATA_W    = 16,
    parameter int unsigned      CRC_W     = 16,
    parameter logic [CRC_W-1:0] POLY      = CRC_W'(CRC16_XMODEM_POLY),
    parameter logic [CRC_W-1:0] INIT      = CRC_W'(CRC16_XMODEM_INIT),
    parameter logic [CRC_W-1:0] XOR_OUT   = CRC_W'(CRC16_XMODEM_XOR_OUT),
    parameter logic [CRC_W-1:0] CHECK_RES = CRC_W'(CRC16_XMODEM_CHECK_RES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_sof,
    input  logic                in_eof,
    input  logic [DATA_W/8-1:0] in_be,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CRC_W-1:0]    out_crc,
    output logic                out_ok,
    output logic                out_abort
);

    localparam int unsigned NB  = DATA_W / 8;
    localparam int unsigned NBW = $clog2(NB + 1);

    state_e           r_state;
    logic             r_live;
    logic [CRC_W-1:0] r_crc;
    logic             r_out_valid;
    logic [CRC_W-1:0] r_out_crc;
    logic             r_out_ok;
    logic             r_out_abort;

    logic             w_accept;
    logic             w_take;
    logic [7:0]       w_be8;
    logic [NBW-1:0]   w_nbytes;
    logic [CRC_W-1:0] w_seed;
    logic [CRC_W-1:0] w_next;

    // In DONE a new beat may only enter together with the result handshake.
    assign in_ready = r_live && ((r_state != DONE) || out_ready);
    assign w_accept = in_valid && in_ready;
    // Beats outside a frame are handshaken but never folded into the CRC.
    assign w_take   = w_accept && (in_sof || (r_state == ACTIVE));
    assign w_be8    = 8'(in_be);
    assign w_nbytes = in_eof ? NBW'(be_popcount(w_be8)) : NBW'(NB);
    assign w_seed   = in_sof ? INIT : r_crc;

    crc_step #(
        .CRC_W  (CRC_W),
        .DATA_W (DATA_W),
        .POLY   (POLY)
    ) u_step (
        .i_crc    (w_seed),
        .i_data   (in_data),
        .i_nbytes (w_nbytes),
        .o_crc    (w_next)
    );

    // Frame FSM with registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_live      <= 1'b0;
            r_crc       <= INIT;
            r_out_valid <= 1'b0;
            r_out_crc   <= '0;
            r_out_ok    <= 1'b0;
            r_out_abort <= 1'b0;
        end else begin
            r_live      <= 1'b1;
            r_out_abort <= w_accept && in_sof && (r_state == ACTIVE);

            case (r_state)
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase

            // A taken beat overrides the DONE release above.
            if (w_take) begin
                r_crc <= w_next;
                if (in_eof) begin
                    r_state     <= DONE;
                    r_out_valid <= 1'b1;
                    r_out_crc   <= w_next ^ XOR_OUT;
                    r_out_ok    <= (w_next == CHECK_RES);
                end else begin
                    r_state     <= ACTIVE;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_crc   = r_out_crc;
    assign out_ok    = r_out_ok;
    assign out_abort = r_out_abort;

`ifndef SYNTHESIS
    // Enabled bytes on an eof beat must be a contiguous MSB-aligned run.
    always_ff @(posedge clk) begin
        if (!rst && w_accept && in_eof) begin
            assert (((~in_be) & ((~in_be) + NB'(1))) == '0);
        end
    end
`endif

endmodule

// File: doc/crc_stream_engine.md
Name: crc_stream_engine

Overview:
- Clocked, streaming, parametrised successor to the fixed 16-bit combinational CRC-16 (poly 1+x^5+x^12+x^16) step.
- Accumulates a CRC over framed multi-beat input with a valid/ready handshake, and handles a partial last beat through byte enables.
- Returns the result on a held output handshake.
- Optional check mode compares the final residue against an expected value; used on link TX (generate) and RX (check) paths.

Parameters:
- DATA_W, 16, input beat width in bits; multiple of 8, range 8..64.
- CRC_W, 16, CRC width in bits, 8..32.
- POLY, 16'h1021, generator polynomial, implicit x^CRC_W term omitted.
- INIT, 16'h0000, CRC register value loaded at start of frame.
- XOR_OUT, 16'h0000, value XORed into the result at end of frame.
- CHECK_RES, 16'h0000, residue expected when frame plus appended CRC is good.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine can accept a beat.
- in_data  in  DATA_W  beat data; MSB byte is the first in the stream.
- in_sof  in  1  beat is the first of a frame.
- in_eof  in  1  beat is the last of a frame.
- in_be  in  DATA_W/8  byte enables, MSB-aligned contiguous; only honoured on eof beats, otherwise treated as all-ones.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_crc  out  CRC_W  final CRC, after XOR_OUT.
- out_ok  out  1  final raw register equals CHECK_RES.
- out_abort  out  1  single-cycle pulse: a frame was restarted by sof before its eof.

Behaviour:
- Reset values:
  - in_ready=0 during rst, 1 on the first cycle after.
  - out_valid=0, out_crc=0, out_ok=0, out_abort=0.
  - State=IDLE; crc register=INIT.
- Arithmetic:
  - Bit-serial MSB-first definition: for each enabled bit d, from data MSB down: fb = crc[CRC_W-1]^d; crc = (crc<<1) ^ (fb ? POLY : 0).
  - A full beat is DATA_W steps. An eof beat with N enabled bytes is 8N steps over the top N bytes.
  - For DATA_W=CRC_W=16 and POLY=0x1021, one full beat must equal the existing combinational step: crc_next = M16·(crc ^ data).
- Beat acceptance: a beat is accepted when in_valid && in_ready.
- States:
  - IDLE: accepted beat with sof goes to ACTIVE, with the crc register computed from INIT. Beats without sof are dropped while still handshaken (in_ready=1). sof&eof on the same beat goes straight to DONE.
  - ACTIVE: each accepted beat updates crc. eof goes to DONE.
    - sof while ACTIVE restarts from INIT with this beat and pulses out_abort one cycle later.
  - DONE:
    - out_valid=1.
    - out_crc = crc ^ XOR_OUT.
    - out_ok = (crc == CHECK_RES).
    - in_ready = out_ready.
    - Outputs stay stable until out_valid && out_ready. On that handshake, return to IDLE, or to ACTIVE/DONE if a sof beat is accepted in the same cycle.
- Latency: out_valid asserts on the cycle after the eof beat is accepted. Throughput is one beat per cycle, including back-to-back frames when out_ready=1.
- in_be all-zero on an eof beat: zero bits processed; the frame closes with the current crc.
- in_be with holes or LSB-aligned: undefined result; a simulation assertion flags it.
- rst mid-frame: the frame is discarded and no out_valid is produced; rst wins over any simultaneous handshake.

Decomposition:
- Package crc_stream_pkg holds:
  - state enum {IDLE, ACTIVE, DONE};
  - default POLY, INIT, XOR_OUT and CHECK_RES constants for CRC-16/XMODEM and CRC-16/CCITT-FALSE;
  - a constant function returning the popcount of a byte-enable vector.
- One sub-module, crc_step:
  - purely combinational, parameters CRC_W, POLY, DATA_W;
  - inputs crc and data, plus nbytes;
  - output next crc, built as a byte-unrolled loop with a per-byte mux.

Test Plan:
- DATA_W=16, defaults: sof beat 0x3132, then 0x3334, 0x3536, 0x3738, then eof beat 0x3900 with be=2'b10 -> out_crc=0x31C3 one cycle after eof, out_ok=0.
- Same stream with INIT=0xFFFF -> out_crc=0x29B1.
- Check mode: "123456789" followed by eof beat 0x31C3, be=2'b11 -> out_ok=1, out_crc=0x0000; corrupt one data bit -> out_ok=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_crc stable and in_ready=0 throughout; on release, the next sof&eof beat 0x0000 gives 0x0000 on the following cycle.
- Abort: sof 0x1234, then sof&eof 0x0000 -> out_abort pulses once, out_crc=0x0000. rst asserted mid-frame -> no out_valid, and the next frame equals a clean run.
- Equivalence: 1000 random single-beat 16-bit frames checked against the existing combinational 16-bit CRC step with crc=INIT.
